video_mux_mode_ctrl: RTL and testbench
======================================

Name: video_mux_mode_ctrl

Overview:
- Controller for the video output mux. Owns the 2-bit background-select and 2-bit overlay-select codes that the mux consumes.
- Takes two raw push-buttons and debounces them. Each press becomes a mode-advance request.
- New selections are committed only at a frame boundary, so the displayed image never changes mid-frame.
- Sits between the board button inputs / video timing generator and the mux select inputs.

Parameters:
- DEBOUNCE_CYCLES, 750_000: consecutive stable synced cycles required to accept a button level change (about 10 ms at 74.25 MHz).
- ALLOW_TEST_OVERLAY, 0: 1 lets the overlay code reach 2'b11 (test colour); 0 makes the overlay code cycle 0->1->2->0.
- AUTO_FRAMES, 120: frame starts between automatic background advances (optional feature only).

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- btn_bg_in  input  1  raw background-advance button, asynchronous
- btn_target_in  input  1  raw overlay-advance button, asynchronous
- frame_start_in  input  1  one-cycle pulse at the first active pixel of each frame
- auto_en_in  input  1  enables auto-cycling (used only when the optional feature is compiled in)
- bg_out  output  2  committed background-select code
- target_out  output  2  committed overlay-select code
- mode_changed_out  output  1  one-cycle pulse, asserted in the cycle the committed codes update
- pending_out  output  1  high while an uncommitted request exists

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - bg_out=0, target_out=0, mode_changed_out=0, pending_out=0.
  - Pending counts cleared, FSM=IDLE.
  - Debouncer synchronisers, counters and stable levels all cleared to 0.
- Debounce:
  - Two-flop synchroniser, then a counter.
  - The counter increments while the synced value differs from the stable level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - A stable-level rising edge produces a one-cycle press pulse. Total latency from raw edge to press pulse is DEBOUNCE_CYCLES+2 cycles.
- Request accumulation:
  - Pending counts pend_bg and pend_tg are 2 bits each.
  - Each press increments its count.
  - pend_bg wraps mod 4.
  - pend_tg wraps mod 4 when ALLOW_TEST_OVERLAY=1, mod 3 otherwise.
- Commit:
  - bg_out <= (bg_out+pend_bg) mod 4.
  - target_out <= (target_out+pend_tg) mod M, where M=4 or 3 per ALLOW_TEST_OVERLAY.
  - Both counts clear to 0 at commit.
- FSM states and transitions:
  - IDLE: a press moves to ARMED. A frame_start_in alone is ignored.
  - ARMED: pending_out=1. On frame_start_in, move to APPLY.
  - APPLY (exactly 1 cycle): commit; mode_changed_out=1 in this cycle and the updated codes are visible on the next edge. Move to ARMED if a press arrives this cycle, otherwise to IDLE.
- Simultaneous events:
  - Press and frame_start in IDLE: the press is recorded and waits for the next frame start.
  - Press and frame_start in ARMED: the press is included in this commit.
  - Press during APPLY: counted for the following commit, not the current one.
  - Both buttons pressed the same cycle: both counts increment.
- Wrap-around examples:
  - Four bg presses before a frame start leave bg_out unchanged, but a commit and mode_changed_out pulse still occur.
  - With ALLOW_TEST_OVERLAY=0, a commit from target_out=2 with pend_tg=1 gives 0.

Optional Feature:
- Macro: VIDEO_MUX_AUTO_CYCLE_EN.
- Defined:
  - A frame counter counts frame_start_in pulses while auto_en_in=1, and clears when auto_en_in=0 or at reset.
  - On the AUTO_FRAMES-th frame start, an implicit bg press is injected (same path as a button press) and the counter clears.
  - The injected press commits at the following frame start, per the IDLE rule.
- Undefined: no counter logic; auto_en_in is ignored.

Decomposition:
- Package video_mode_pkg holds:
  - bg_mode_t enum: CAM=0, CHAN=1, THRESH=2, YMASK=3.
  - overlay_mode_t enum: NONE=0, CROSSHAIR=1, SPRITE=2, TESTCOL=3.
  - ctrl_state_t enum: IDLE, ARMED, APPLY.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk_in, rst_in, raw_in, level_out, press_out), instantiated twice.
- The bench uses DEBOUNCE_CYCLES=8.

Test Plan:
- Reset mid-ARMED: pend_bg=2, assert rst_in -> outputs 0 immediately; the next frame_start_in produces no mode_changed_out.
- Debounce: btn_bg_in glitch high for 5 cycles -> no press. Held high for 20 cycles -> one press at cycle 10 after the edge; pending_out=1, and bg_out=1 after the next frame_start_in plus 1 cycle.
- Accumulate and wrap: 5 bg presses, then frame_start_in -> bg_out=1, with a single mode_changed_out pulse.
- Overlay wrap, ALLOW_TEST_OVERLAY=0: target_out=2, one press, frame start -> target_out=0. Repeat with ALLOW_TEST_OVERLAY=1 -> target_out=3.
- Simultaneous events:
  - Press coincident with frame_start_in in IDLE -> commits at the second frame start.
  - Coincident press in ARMED -> included in that commit.
- Auto-cycle (macro defined, AUTO_FRAMES=3, auto_en_in=1): after 3 frame starts -> pending; at the 4th -> bg_out increments.

Source files
------------

// File: rtl/video_mode_pkg.sv
// rtl/video_mode_pkg.sv - shared mode encodings and wrap arithmetic for the video mux controller
package video_mode_pkg;

    typedef enum logic [1:0] {
        CAM    = 2'd0,
        CHAN   = 2'd1,
        THRESH = 2'd2,
        YMASK  = 2'd3
    } bg_mode_t;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        CROSSHAIR = 2'd1,
        SPRITE    = 2'd2,
        TESTCOL   = 2'd3
    } overlay_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } ctrl_state_t;

    // Add two 2-bit codes modulo 4, or modulo 3 when mod3 is set.
    // Operands are always below the modulus, so one subtraction is enough.
    function automatic logic [1:0] wrap_add(input logic [1:0] a,
                                            input logic [1:0] b,
                                            input logic       mod3);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (mod3 && (s >= 3'd3)) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/video_mux_mode_ctrl_if.sv
// rtl/video_mux_mode_ctrl_if.sv - committed select codes and status toward the video mux
interface video_mux_mode_ctrl_if;
    import video_mode_pkg::*;

    bg_mode_t      bg_out;
    overlay_mode_t target_out;
    logic          mode_changed_out;
    logic          pending_out;

    modport master (
        output bg_out,
        output target_out,
        output mode_changed_out,
        output pending_out
    );

    modport slave (
        input bg_out,
        input target_out,
        input mode_changed_out,
        input pending_out
    );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus stability counter, one-cycle press pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 750_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          stable_q;
    logic          press_q;

    // Synchronise the raw input, then accept a level only after it held for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_in};
            press_q <= 1'b0;
            if (sync_q[1] != stable_q) begin
                if (cnt_q == LAST) begin
                    stable_q <= sync_q[1];
                    cnt_q    <= '0;
                    press_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_out = stable_q;
    assign press_out = press_q;

endmodule

// File: rtl/video_mux_mode_ctrl.sv
// rtl/video_mux_mode_ctrl.sv - debounced mode requests committed at frame start; VIDEO_MUX_AUTO_CYCLE_EN adds timed background advance
module video_mux_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 750_000,
    parameter bit ALLOW_TEST_OVERLAY = 1'b0,
    parameter int AUTO_FRAMES        = 120
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  btn_bg_in,
    input  logic                  btn_target_in,
    input  logic                  frame_start_in,
    input  logic                  auto_en_in,
    video_mux_mode_ctrl_if.master mux
);

    localparam logic TG_MOD3 = !ALLOW_TEST_OVERLAY;

    logic press_bg;
    logic press_tg;
    logic auto_press;
    logic bg_req;
    logic tg_req;
    logic any_req;
    logic unused_bg_level;
    logic unused_tg_level;

    ctrl_state_t   state_q;
    logic [1:0]    pend_bg_q;
    logic [1:0]    pend_tg_q;
    logic [1:0]    pend_bg_nxt;
    logic [1:0]    pend_tg_nxt;
    bg_mode_t      bg_q;
    overlay_mode_t tg_q;
    logic          changed_q;
    logic          pending_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bg (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_bg_in),
        .level_out (unused_bg_level),
        .press_out (press_bg)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tg (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_target_in),
        .level_out (unused_tg_level),
        .press_out (press_tg)
    );

`ifdef VIDEO_MUX_AUTO_CYCLE_EN
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

    logic [FW-1:0] frame_cnt_q;

    assign auto_press = auto_en_in && frame_start_in && (frame_cnt_q == FRAME_LAST);

    // Count frame starts while auto-cycling is enabled; wrap when an advance is injected.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt_q <= '0;
        end else if (!auto_en_in) begin
            frame_cnt_q <= '0;
        end else if (frame_start_in) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_q <= '0;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end
`else
    logic        unused_auto_en;
    logic [31:0] unused_auto_frames;

    assign auto_press         = 1'b0;
    assign unused_auto_en     = auto_en_in;
    assign unused_auto_frames = AUTO_FRAMES;
`endif

    assign bg_req  = press_bg | auto_press;
    assign tg_req  = press_tg;
    assign any_req = bg_req | tg_req;

    assign pend_bg_nxt = wrap_add(pend_bg_q, {1'b0, bg_req}, 1'b0);
    assign pend_tg_nxt = wrap_add(pend_tg_q, {1'b0, tg_req}, TG_MOD3);

    // Request accumulation and frame-aligned commit; a press during APPLY starts the next batch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            pend_bg_q <= 2'd0;
            pend_tg_q <= 2'd0;
            bg_q      <= CAM;
            tg_q      <= NONE;
            changed_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pend_bg_q <= pend_bg_nxt;
                    pend_tg_q <= pend_tg_nxt;
                    if (any_req) begin
                        state_q   <= ARMED;
                        pending_q <= 1'b1;
                    end
                end
                ARMED: begin
                    pend_bg_q <= pend_bg_nxt;
                    pend_tg_q <= pend_tg_nxt;
                    if (frame_start_in) begin
                        state_q   <= APPLY;
                        changed_q <= 1'b1;
                    end
                end
                APPLY: begin
                    bg_q      <= bg_mode_t'(wrap_add(bg_q, pend_bg_q, 1'b0));
                    tg_q      <= overlay_mode_t'(wrap_add(tg_q, pend_tg_q, TG_MOD3));
                    pend_bg_q <= {1'b0, bg_req};
                    pend_tg_q <= {1'b0, tg_req};
                    if (any_req) begin
                        state_q <= ARMED;
                    end else begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign mux.bg_out           = bg_q;
    assign mux.target_out       = tg_q;
    assign mux.mode_changed_out = changed_q;
    assign mux.pending_out      = pending_q;

endmodule

// File: tb/tb_video_mux_mode_ctrl.sv
// tb/tb_video_mux_mode_ctrl.sv - directed self-checking bench, overlay wrap checked with test colour off and on
`timescale 1ns/1ps
module tb_video_mux_mode_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_bg = 1'b0;
    logic btn_tg = 1'b0;
    logic frame_start = 1'b0;
    logic auto_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int mc_cnt = 0;
    int mc_base;

    video_mux_mode_ctrl_if mux0 ();
    video_mux_mode_ctrl_if mux1 ();

    video_mux_mode_ctrl #(
        .DEBOUNCE_CYCLES    (8),
        .ALLOW_TEST_OVERLAY (1'b0),
        .AUTO_FRAMES        (3)
    ) dut0 (
        .clk_in         (clk),
        .rst_in         (rst),
        .btn_bg_in      (btn_bg),
        .btn_target_in  (btn_tg),
        .frame_start_in (frame_start),
        .auto_en_in     (auto_en),
        .mux            (mux0)
    );

    video_mux_mode_ctrl #(
        .DEBOUNCE_CYCLES    (8),
        .ALLOW_TEST_OVERLAY (1'b1),
        .AUTO_FRAMES        (3)
    ) dut1 (
        .clk_in         (clk),
        .rst_in         (rst),
        .btn_bg_in      (btn_bg),
        .btn_target_in  (btn_tg),
        .frame_start_in (frame_start),
        .auto_en_in     (auto_en),
        .mux            (mux1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mux0.mode_changed_out === 1'b1) mc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic b, input logic t);
        btn_bg = b;
        btn_tg = t;
        tick(12);
        btn_bg = 1'b0;
        btn_tg = 1'b0;
        tick(12);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_bg", mux0.bg_out, 0);
        check("rst_tg", mux0.target_out, 0);
        check("rst_mc", mux0.mode_changed_out, 0);
        check("rst_pend", mux0.pending_out, 0);
        rst = 1'b0;
        tick(2);

        // glitch shorter than the debounce window
        btn_bg = 1'b1;
        tick(5);
        btn_bg = 1'b0;
        tick(15);
        check("glitch_pend", mux0.pending_out, 0);

        // press latency: pulse at cycle 10, pending visible after cycle 11
        btn_bg = 1'b1;
        tick(10);
        check("lat_pend_early", mux0.pending_out, 0);
        tick(1);
        check("lat_pend", mux0.pending_out, 1);
        tick(9);
        btn_bg = 1'b0;
        tick(12);
        frame();
        check("apply_mc", mux0.mode_changed_out, 1);
        check("apply_bg_old", mux0.bg_out, 0);
        tick(1);
        check("commit_bg", mux0.bg_out, 1);
        check("commit_mc_off", mux0.mode_changed_out, 0);
        check("commit_pend", mux0.pending_out, 0);
        tick(2);

        // five presses wrap pend_bg to 1
        mc_base = mc_cnt;
        repeat (5) press(1'b1, 1'b0);
        frame();
        tick(3);
        check("acc_bg", mux0.bg_out, 2);
        check("acc_mc_once", mc_cnt - mc_base, 1);

        // overlay wrap mod 3 vs mod 4
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        frame();
        tick(3);
        check("tg2_m3", mux0.target_out, 2);
        check("tg2_m4", mux1.target_out, 2);
        press(1'b0, 1'b1);
        frame();
        tick(3);
        check("tgwrap_m3", mux0.target_out, 0);
        check("tgwrap_m4", mux1.target_out, 3);

        // press coincident with frame start in IDLE waits for the next frame
        mc_base = mc_cnt;
        btn_bg = 1'b1;
        tick(10);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("idle_coinc_pend", mux0.pending_out, 1);
        btn_bg = 1'b0;
        tick(12);
        check("idle_coinc_hold", mux0.bg_out, 2);
        check("idle_coinc_nomc", mc_cnt - mc_base, 0);
        frame();
        tick(2);
        check("idle_coinc_bg", mux0.bg_out, 3);

        // press coincident with frame start in ARMED joins that commit
        press(1'b1, 1'b0);
        mc_base = mc_cnt;
        btn_bg = 1'b1;
        tick(10);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        btn_bg = 1'b0;
        tick(12);
        check("armed_coinc_bg", mux0.bg_out, 1);
        check("armed_coinc_mc", mc_cnt - mc_base, 1);
        check("armed_coinc_pend", mux0.pending_out, 0);

        // both buttons in the same cycle
        press(1'b1, 1'b1);
        frame();
        tick(3);
        check("both_bg", mux0.bg_out, 2);
        check("both_tg_m3", mux0.target_out, 1);
        check("both_tg_m4", mux1.target_out, 0);

        // asynchronous reset while ARMED with pend_bg=2
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pre_rst_pend", mux0.pending_out, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_bg", mux0.bg_out, 0);
        check("arst_tg", mux0.target_out, 0);
        check("arst_pend", mux0.pending_out, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        mc_base = mc_cnt;
        frame();
        tick(3);
        check("post_rst_nomc", mc_cnt - mc_base, 0);
        check("post_rst_bg", mux0.bg_out, 0);

        auto_en = 1'b1;
`ifdef VIDEO_MUX_AUTO_CYCLE_EN
        repeat (3) begin
            frame();
            tick(3);
        end
        check("auto_pend", mux0.pending_out, 1);
        check("auto_bg_hold", mux0.bg_out, 0);
        frame();
        tick(2);
        check("auto_bg", mux0.bg_out, 1);
`else
        repeat (4) begin
            frame();
            tick(3);
        end
        check("noauto_pend", mux0.pending_out, 0);
        check("noauto_bg", mux0.bg_out, 0);
`endif
        auto_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
